// File: rtl/spi_controller_pkg.sv
// Shared definitions for the SPI frame-buffer streamer: mode constants,
// default widths and the controller state encoding.
package spi_controller_pkg;
    localparam int DATA_WIDTH_DEF   = 8;
    localparam int ADDR_WIDTH_DEF   = 11;
    localparam int LAST_ADDRESS_DEF = 1535;

    // Mode 0: sck idles low, host samples on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;
endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizer plus history flop; emits the synchronized level and
// single-cycle rise/fall pulses for an asynchronous pin.
module spi_input_sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic       meta;
    logic       sync;
    logic       hist;
    logic [1:0] settle;
    logic       settled;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= RESET_VALUE;
            sync   <= RESET_VALUE;
            hist   <= RESET_VALUE;
            settle <= 2'd0;
        end else begin
            meta <= din;
            sync <= meta;
            hist <= sync;
            if (settle != 2'd3)
                settle <= settle + 2'd1;
        end
    end

    // Until the pin value has walked through all three flops, a pin that differs
    // from RESET_VALUE would look like an edge; hold the pulses off until then.
    assign settled = (settle == 2'd3);
    assign level   = sync;
    assign rise    = settled &  sync & ~hist;
    assign fall    = settled & ~sync &  hist;
endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 read-only peripheral: streams a byte buffer out on cipo while the
// host clocks sck with cs low, walking data_address sequentially with wrap.
module spi_controller
    import spi_controller_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int LAST_ADDRESS = LAST_ADDRESS_DEF
) (
    input  logic                  hf_clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  cs,
    output logic                  cipo,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] data_address,
    output logic                  busy
);
    localparam int                  CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LAST_ADDRESS);

    logic sck_level, sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;

    spi_input_sync #(.RESET_VALUE(1'b0)) u_sck_sync (
        .clk   (hf_clk),
        .reset (reset),
        .din   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_input_sync #(.RESET_VALUE(1'b1)) u_cs_sync (
        .clk   (hf_clk),
        .reset (reset),
        .din   (cs),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    state_t                  state, state_next;
    logic [CNT_W-1:0]        bit_cnt, cnt_next;
    logic [DATA_WIDTH-1:0]   shreg, shreg_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic                    load_cnt, load_next;

    always_ff @(posedge hf_clk) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            data_address <= '0;
            load_cnt     <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= cnt_next;
            shreg        <= shreg_next;
            data_address <= addr_next;
            load_cnt     <= load_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        shreg_next = shreg;
        addr_next  = data_address;
        load_next  = load_cnt;
        // cs release beats any sck edge seen in the same cycle; partial bytes are dropped.
        if (cs_rise || (cs_level && state != IDLE)) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_next = LOAD;
                        addr_next  = '0;
                        cnt_next   = '0;
                        load_next  = 1'b0;
                    end
                end
                LOAD: begin
                    load_next = 1'b1;
                    if (load_cnt) begin
                        shreg_next = data;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        if (bit_cnt == CNT_LAST) begin
                            cnt_next  = '0;
                            addr_next = (data_address == LAST_ADDR) ? '0 : data_address + 1'b1;
                        end else begin
                            cnt_next = bit_cnt + 1'b1;
                        end
                    end else if (sck_fall && !sck_level) begin
                        // Counter at zero marks a byte boundary; the RAM has long since
                        // answered the address bumped on the preceding rising edge.
                        if (bit_cnt != '0)
                            shreg_next = {shreg[DATA_WIDTH-2:0], 1'b0};
                        else
                            shreg_next = data;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign cipo = (state == SHIFT) && shreg[DATA_WIDTH-1];
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: a host model drives sck/cs, expected bytes
// are queued per transaction and a monitor assembles cipo bits and compares.
module tb_spi_controller;
    localparam int HALF = 25;  // hf_clk 50 MHz, sck 1 MHz

    logic        hf_clk = 1'b0;
    logic        reset  = 1'b1;
    logic        sck    = 1'b0;
    logic        cs     = 1'b1;
    logic        cipo0, cipo1, busy0, busy1;
    logic [7:0]  data0, data1;
    logic [10:0] addr0, addr1;
    logic        a5_mode = 1'b0;
    logic        mon_en  = 1'b1;

    int tests = 0;
    int fails = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         nbits = 0;
    logic [7:0] sh0 = '0;
    logic [7:0] sh1 = '0;

    spi_controller dut (
        .hf_clk       (hf_clk),
        .reset        (reset),
        .sck          (sck),
        .cs           (cs),
        .cipo         (cipo0),
        .data         (data0),
        .data_address (addr0),
        .busy         (busy0)
    );

    spi_controller #(.LAST_ADDRESS(3)) dut_wrap (
        .hf_clk       (hf_clk),
        .reset        (reset),
        .sck          (sck),
        .cs           (cs),
        .cipo         (cipo1),
        .data         (data1),
        .data_address (addr1),
        .busy         (busy1)
    );

    always #10 hf_clk = ~hf_clk;

    function automatic logic [7:0] ram(input logic [10:0] a);
        return (a5_mode && a == 11'd0) ? 8'hA5 : a[7:0];
    endfunction

    always @(posedge hf_clk) begin
        data0 <= ram(addr0);
        data1 <= ram(addr1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: host samples cipo on each sck rise while selected.
    always @(posedge sck or posedge cs) begin
        if (cs) begin
            nbits = 0;
        end else if (mon_en) begin
            sh0 = {sh0[6:0], cipo0};
            sh1 = {sh1[6:0], cipo1};
            nbits++;
            if (nbits == 8) begin
                nbits = 0;
                if (q0.size() == 0 || q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0h/%0h, expected none", sh0, sh1);
                end else begin
                    check("byte_dut", 32'(sh0), 32'(q0.pop_front()));
                    check("byte_dut_wrap", 32'(sh1), 32'(q1.pop_front()));
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge hf_clk);
    endtask

    task automatic sck_cycles(input int n);
        repeat (n) begin
            wait_clk(HALF);
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic host_select();
        cs = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic host_release();
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic push(input logic [7:0] b0, input logic [7:0] b1);
        q0.push_back(b0);
        q1.push_back(b1);
    endtask

    initial begin
        wait_clk(5);
        check("reset_cipo", 32'(cipo0), 32'd0);
        check("reset_busy", 32'(busy0), 32'd0);
        check("reset_addr", 32'(addr0), 32'd0);
        reset = 1'b0;
        wait_clk(5);

        // single byte A5
        a5_mode = 1'b1;
        push(8'hA5, 8'hA5);
        host_select();
        check("single_busy", 32'(busy0), 32'd1);
        sck_cycles(8);
        check("single_addr", 32'(addr0), 32'd1);
        host_release();
        check("single_idle_busy", 32'(busy0), 32'd0);
        check("single_idle_cipo", 32'(cipo0), 32'd0);

        // 4-byte burst, RAM = address
        a5_mode = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(i), 8'(i));
        host_select();
        sck_cycles(32);
        check("burst_addr", 32'(addr0), 32'd4);
        check("burst_addr_wrap", 32'(addr1), 32'd0);
        host_release();

        // 6-byte burst: the LAST_ADDRESS=3 instance wraps 3 -> 0
        for (int i = 0; i < 6; i++) push(8'(i), 8'(i % 4));
        host_select();
        sck_cycles(48);
        check("wrap_addr", 32'(addr0), 32'd6);
        check("wrap_addr_wrap", 32'(addr1), 32'd2);
        host_release();

        // abort after 3 bits; cs rise coincides with the 3rd sck fall
        a5_mode = 1'b1;
        host_select();
        sck_cycles(3);
        cs = 1'b1;
        wait_clk(4);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_cipo", 32'(cipo0), 32'd0);
        check("abort_addr", 32'(addr0), 32'd0);
        wait_clk(HALF);
        push(8'hA5, 8'hA5);
        host_select();
        sck_cycles(8);
        check("after_abort_addr", 32'(addr0), 32'd1);
        host_release();

        // reset mid-transfer with cs held low
        a5_mode = 1'b0;
        push(8'h00, 8'h00);
        host_select();
        sck_cycles(8);
        mon_en = 1'b0;
        sck_cycles(3);
        reset = 1'b1;
        wait_clk(1);
        check("midreset_cipo", 32'(cipo0), 32'd0);
        check("midreset_busy", 32'(busy0), 32'd0);
        check("midreset_addr", 32'(addr0), 32'd0);
        reset = 1'b0;
        sck_cycles(5);
        check("postreset_busy", 32'(busy0), 32'd0);
        check("postreset_cipo", 32'(cipo0), 32'd0);
        check("postreset_addr", 32'(addr0), 32'd0);
        cs = 1'b1;
        wait_clk(HALF);
        mon_en = 1'b1;
        push(8'h00, 8'h00);
        push(8'h01, 8'h01);
        host_select();
        sck_cycles(16);
        check("restart_addr", 32'(addr0), 32'd2);
        host_release();

        // sck noise with cs high
        for (int i = 0; i < 10; i++) begin
            wait_clk(4);
            sck = 1'b1;
            wait_clk(4);
            sck = 1'b0;
            if (i % 3 == 0) begin
                check("noise_cipo", 32'(cipo0), 32'd0);
                check("noise_busy", 32'(busy0), 32'd0);
                check("noise_addr", 32'(addr0), 32'd2);
            end
        end
        wait_clk(10);
        check("noise_final_addr", 32'(addr0), 32'd2);

        check("queue_empty", 32'(q0.size()), 32'd0);
        check("queue_empty_wrap", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI peripheral, read-only streamer: an external SPI host (e.g. the MCU) clocks a byte buffer (thermal frame memory) out of the FPGA over sck/cs/cipo.
- Generates a sequential byte address into a synchronous buffer, takes the returned byte, and shifts it out MSB first.
- Sits between the frame-buffer RAM and the package SPI pins.
- SPI mode 0 (CPOL=0, CPHA=0), cs active-low; sck and cs are oversampled in the hf_clk domain.

Parameters:
- DATA_WIDTH, 8, bits per SPI word and per buffer entry.
- ADDR_WIDTH, 11, width of data_address.
- LAST_ADDRESS, 1535, final buffer address; the address after it wraps to 0.

Ports:
- hf_clk  input  1  system clock; must be at least 8x the sck frequency.
- reset  input  1  synchronous, active-high reset.
- sck  input  1  SPI clock from the host; asynchronous to hf_clk.
- cs  input  1  SPI chip select from the host; active-low, asynchronous to hf_clk.
- cipo  output  1  SPI serial data to the host.
- data  input  DATA_WIDTH  byte returned by the buffer for data_address; valid one hf_clk after the address changes.
- data_address  output  ADDR_WIDTH  buffer read address.
- busy  output  1  high while a transaction is active (synchronized cs low).

Behaviour:
- One clock (hf_clk); reset is synchronous and active-high. All logic is in the hf_clk domain.
- Reset values: cipo=0, data_address=0, busy=0, bit counter=0, shift register=0, state=IDLE.
- sck and cs each pass through a 2-flop synchronizer plus one history flop for edge detection. Edge pulses are one hf_clk wide, 3 hf_clk after the pin change.
- States:
  - IDLE: cipo=0. On cs falling edge go to LOAD, set data_address=0, bit counter=0.
  - LOAD: wait 2 hf_clk for the RAM. On the 2nd cycle latch data into the shift register and go to SHIFT. cipo = shift register MSB from then on.
  - SHIFT: on each sck rising edge, bit counter increments. When the counter wraps 7->0 (8th rising edge), data_address increments, or wraps from LAST_ADDRESS to 0. On each sck falling edge, if the counter is nonzero, shift left by 1 (LSB fill 0). If the counter is 0, a byte boundary has occurred: load the shift register from data, which is valid because at least 4 hf_clk have elapsed since the address increment.
- cs rising edge in any state: return to IDLE, cipo=0, busy=0. A partial byte is discarded and data_address holds its value. The next cs fall restarts at address 0.
- sck edges while IDLE are ignored.
- Simultaneous cs rise and sck edge in the same hf_clk: cs wins.
- Reset while cs is low: the block stays IDLE until a fresh cs falling edge is seen. Because the edge-detect history flops reset to 1 for cs and 0 for sck, no spurious edge is produced.
- busy = (state != IDLE).

Decomposition:
- Shared package: SPI mode constants, the DATA_WIDTH/ADDR_WIDTH defaults, and the state enum (IDLE, LOAD, SHIFT).
- One natural sub-module: spi_input_sync, a 2-flop synchronizer plus edge detector. It has a RESET_VALUE parameter and outputs a level, a rise pulse and a fall pulse. It is instantiated once for sck and once for cs.

Test Plan:
- Single byte: RAM model returns 8'hA5 at address 0; cs low, 8 sck cycles at 1 MHz with hf_clk at 50 MHz. Host samples 1,0,1,0,0,1,0,1 on rising edges. data_address=1 after the 8th rise.
- Burst: RAM holds address[7:0]; cs low for 4 bytes. Host receives 8'h00, 8'h01, 8'h02, 8'h03, and data_address ends at 4.
- Wrap: LAST_ADDRESS=3, 6-byte burst. Addresses go 0,1,2,3,0,1, and the received bytes match.
- Abort: cs rises after 3 bits of byte 0. busy=0 and cipo=0 within 4 hf_clk. The next transaction starts at address 0 and outputs the full byte 0.
- Reset mid-transfer: assert reset for 1 hf_clk during byte 1 with cs held low. Outputs take reset values and sck edges are ignored. A new cs fall->rise->fall restarts at address 0.
- Idle noise: toggle sck with cs high. cipo stays 0, data_address does not change, busy stays 0.
